// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, IO access width
// code and default bus widths.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [2:0] ACCESS_WORD = 3'b010;

  typedef enum logic {
    ARB      = 1'b0,
    IO_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_burst_ctr.sv
// IO burst address generator: loads base+1 on burst entry, steps per granted
// beat, wraps modulo 2^ADDR_W and flags the final beat.
module arb_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = base_i + ADDR_W'(1);
      cnt_d  = CNT_LOAD;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU fixed priority, IO starvation override and
// IO bursts. Optional grant/conflict statistics under `DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_access_type,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_burst,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic [2:0]        mem_access_type,
  input  logic [DATA_W-1:0] mem_dataOut
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_cpu_grants,
  output logic [15:0]       stat_io_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              cpu_rvalid_q, io_rvalid_q;
  logic              burst_load, burst_step, burst_last;
  logic [ADDR_W-1:0] burst_addr;

  arb_burst_ctr #(
    .ADDR_W   (ADDR_W),
    .BURST_LEN(BURST_LEN)
  ) u_burst_ctr (
    .clock  (clock),
    .reset_n(reset_n),
    .load_i (burst_load),
    .step_i (burst_step),
    .base_i (io_addr),
    .addr_o (burst_addr),
    .last_o (burst_last)
  );

  // Grants are gated by reset_n so nothing reaches the RAM while reset is held.
  always_comb begin
    cpu_gnt    = 1'b0;
    io_gnt     = 1'b0;
    burst_load = 1'b0;
    burst_step = 1'b0;
    state_d    = state_q;
    if (reset_n) begin
      case (state_q)
        ARB: begin
          if (io_req && ((starve_q == STARVE_LIM) || !cpu_req)) begin
            io_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
          if (io_gnt && io_burst) begin
            burst_load = 1'b1;
            state_d    = IO_BURST;
          end
        end
        IO_BURST: begin
          io_gnt     = io_req;
          burst_step = io_req;
          if (!io_req || burst_last) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    mem_wEn         = 1'b0;
    mem_addr        = '0;
    mem_dataIn      = '0;
    mem_access_type = '0;
    if (cpu_gnt) begin
      mem_wEn         = cpu_we;
      mem_addr        = cpu_addr;
      mem_dataIn      = cpu_wdata;
      mem_access_type = cpu_access_type;
    end else if (io_gnt) begin
      mem_wEn         = io_we;
      mem_addr        = (state_q == IO_BURST) ? burst_addr : io_addr;
      mem_dataIn      = io_wdata;
      mem_access_type = ACCESS_WORD;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (io_gnt) begin
      starve_d = '0;
    end else if (io_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      io_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      io_rvalid_q  <= io_gnt & ~io_we;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign io_rvalid  = io_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_dataOut : '0;
  assign io_rdata   = io_rvalid_q ? mem_dataOut : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] st_cpu_q, st_io_q, st_conf_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_cpu_q  <= '0;
      st_io_q   <= '0;
      st_conf_q <= '0;
    end else if (stat_clr) begin
      st_cpu_q  <= '0;
      st_io_q   <= '0;
      st_conf_q <= '0;
    end else begin
      if (cpu_gnt && (st_cpu_q != '1))            st_cpu_q  <= st_cpu_q + 16'd1;
      if (io_gnt && (st_io_q != '1))              st_io_q   <= st_io_q + 16'd1;
      if (cpu_req && io_req && (st_conf_q != '1)) st_conf_q <= st_conf_q + 16'd1;
    end
  end

  assign stat_cpu_grants = st_cpu_q;
  assign stat_io_grants  = st_io_q;
  assign stat_conflicts  = st_conf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-level reference model and a
// behavioural RAM; directed phases cover latency, starvation, wrap, abort, reset.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BL = 16;
  localparam int SM = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [2:0]    cpu_access_type = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          io_req = 1'b0, io_burst = 1'b0, io_we = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic          io_gnt, io_rvalid;
  logic [DW-1:0] io_rdata;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn;
  logic [2:0]    mem_access_type;
  logic [DW-1:0] mem_dataOut;
`ifdef DMEM_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_cpu_grants, stat_io_grants, stat_conflicts;
`endif

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_LEN (BL),
    .STARVE_MAX(SM)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_access_type(cpu_access_type),
    .cpu_gnt        (cpu_gnt),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .io_req         (io_req),
    .io_burst       (io_burst),
    .io_we          (io_we),
    .io_addr        (io_addr),
    .io_wdata       (io_wdata),
    .io_gnt         (io_gnt),
    .io_rvalid      (io_rvalid),
    .io_rdata       (io_rdata),
    .mem_wEn        (mem_wEn),
    .mem_addr       (mem_addr),
    .mem_dataIn     (mem_dataIn),
    .mem_access_type(mem_access_type),
    .mem_dataOut    (mem_dataOut)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_cpu_grants(stat_cpu_grants),
    .stat_io_grants (stat_io_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clock = ~clock;

  // Environment RAM driven by the DUT; ref_mem is the model's own copy.
  logic [DW-1:0] ram     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  always @(posedge clock) begin
    if (mem_wEn) ram[mem_addr] <= mem_dataIn;
    mem_dataOut <= ram[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_wait = 0;     // consecutive cycles IO has been refused
  bit          m_burst = 0;
  int          m_base = 0;
  int          m_beat = 0;     // beats already done in current burst
  bit          m_crv = 0, m_irv = 0;
  logic [31:0] m_crd = '0, m_ird = '0;
  int          m_sc = 0, m_si = 0, m_sk = 0;

  task automatic step();
    bit          eg_c, eg_i, ew;
    logic [11:0] ea;
    logic [31:0] ed;
    logic [2:0]  et;
    #1;
    if (!reset_n) begin
      m_wait = 0; m_burst = 0; m_beat = 0;
      m_crv = 0; m_irv = 0;
      m_sc = 0; m_si = 0; m_sk = 0;
      eg_c = 0; eg_i = 0;
    end else if (m_burst) begin
      eg_i = io_req; eg_c = 0;
    end else begin
      eg_i = io_req && (m_wait >= SM || !cpu_req);
      eg_c = cpu_req && !eg_i;
    end
    ew = 0; ea = '0; ed = '0; et = '0;
    if (eg_c) begin
      ew = cpu_we; ea = cpu_addr; ed = cpu_wdata; et = cpu_access_type;
    end else if (eg_i) begin
      ew = io_we;
      ea = m_burst ? 12'((m_base + m_beat) % 4096) : io_addr;
      ed = io_wdata; et = 3'b010;
    end
    check_val("cpu_gnt", cpu_gnt, eg_c);
    check_val("io_gnt", io_gnt, eg_i);
    check_val("mem_wEn", mem_wEn, ew);
    check_val("mem_addr", mem_addr, ea);
    check_val("mem_dataIn", mem_dataIn, ed);
    check_val("mem_access_type", mem_access_type, et);
    check_val("cpu_rvalid", cpu_rvalid, m_crv);
    check_val("cpu_rdata", cpu_rdata, m_crv ? m_crd : 32'd0);
    check_val("io_rvalid", io_rvalid, m_irv);
    check_val("io_rdata", io_rdata, m_irv ? m_ird : 32'd0);
`ifdef DMEM_ARB_STATS_EN
    check_val("stat_cpu_grants", stat_cpu_grants, m_sc);
    check_val("stat_io_grants", stat_io_grants, m_si);
    check_val("stat_conflicts", stat_conflicts, m_sk);
`endif
    if (reset_n) begin
      m_crv = eg_c && !cpu_we;
      m_irv = eg_i && !io_we;
      if (m_crv) m_crd = ref_mem[ea];
      if (m_irv) m_ird = ref_mem[ea];
      if (ew) ref_mem[ea] = ed;
      if (eg_i) m_wait = 0;
      else if (io_req) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
      if (m_burst) begin
        if (!io_req) m_burst = 0;
        else begin
          m_beat++;
          if (m_beat == BL) m_burst = 0;
        end
      end else if (eg_i && io_burst) begin
        m_burst = 1; m_base = io_addr; m_beat = 1;
      end
`ifdef DMEM_ARB_STATS_EN
      if (stat_clr) begin
        m_sc = 0; m_si = 0; m_sk = 0;
      end else begin
        if (eg_c && m_sc < 65535) m_sc++;
        if (eg_i && m_si < 65535) m_si++;
        if (cpu_req && io_req && m_sk < 65535) m_sk++;
      end
`endif
    end
    @(negedge clock);
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_access_type = '0;
    io_req = 0; io_burst = 0; io_we = 0; io_addr = '0; io_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    idle();
    @(negedge clock);
    step(); step();
    reset_n = 1;
    step();

    // Read latency on RAM[5]
    cpu_req = 1; cpu_addr = 12'd5; cpu_access_type = 3'b010;
    step();
    idle();
    step();

    // Starvation: both requesting for 10 cycles
`ifdef DMEM_ARB_STATS_EN
    stat_clr = 1; step(); stat_clr = 0;
`endif
    cpu_req = 1; cpu_addr = 12'd7; io_req = 1; io_addr = 12'd9;
    repeat (10) step();
    idle();
    step();
`ifdef DMEM_ARB_STATS_EN
    check_val("stat_conflicts_10", stat_conflicts, 16'd10);
    check_val("stat_cpu_grants_9", stat_cpu_grants, 16'd9);
    check_val("stat_io_grants_1", stat_io_grants, 16'd1);
    stat_clr = 1; step(); stat_clr = 0;
    step();
`endif

    // Read burst wrapping past 4095 with CPU contending
    cpu_req = 1; cpu_addr = 12'd33;
    io_req = 1; io_burst = 1; io_addr = 12'd4090;
    repeat (18) step();
    idle();
    step();

    // Abort after beat 3
    cpu_req = 1; cpu_addr = 12'd40;
    io_req = 1; io_burst = 1; io_addr = 12'd100;
    repeat (4) step();
    io_req = 0; io_burst = 0;
    repeat (3) step();
    idle();
    step();

    // Write burst interrupted by reset at beat 5
    io_req = 1; io_burst = 1; io_we = 1; io_addr = 12'd2000;
    for (int b = 0; b < 5; b++) begin
      io_wdata = $urandom;
      step();
    end
    reset_n = 0;
    step(); step();
    reset_n = 1; io_we = 0; io_addr = 12'd300;
    repeat (6) step();
    idle();
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cpu_req = ($urandom_range(0, 99) < 55);
      cpu_we = $urandom_range(0, 1);
      cpu_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
      cpu_wdata = $urandom;
      cpu_access_type = 3'($urandom);
      io_req = m_burst ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 45);
      io_burst = ($urandom_range(0, 9) == 0);
      io_we = $urandom_range(0, 1);
      io_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4080, 4095)) : 12'($urandom_range(0, 31));
      io_wdata = $urandom;
      reset_n = ($urandom_range(0, 999) != 0);
`ifdef DMEM_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 199) == 0);
`endif
      step();
    end
    reset_n = 1;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: CPU load/store traffic (port 0) and the IO/VGA frame fetcher (port 1).
- Sits in front of the 12-bit-address, 32-bit-data DualRWRAM port, so CPU and IO can later collapse onto one RAM port.
- CPU has fixed priority. A starvation counter lifts IO above the CPU, and IO may claim fixed-length read/write bursts with arbiter-generated addresses.

Parameters:
- ADDR_W, 12, memory word-address width (4096-entry RAM)
- DATA_W, 32, data width
- BURST_LEN, 16, beats per IO burst (>=2)
- STARVE_MAX, 8, consecutive denied IO cycles before IO gains priority (>=1)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  store data
- cpu_access_type  in  3  RISC-V funct3 width code, passed to RAM
- cpu_gnt  out  1  CPU owns the port this cycle
- cpu_rvalid  out  1  load data valid (one cycle after a read grant)
- cpu_rdata  out  DATA_W  load data
- io_req  in  1  IO request
- io_burst  in  1  with io_req: request a BURST_LEN-beat burst
- io_we  in  1  IO write
- io_addr  in  ADDR_W  IO address; burst base address when io_burst=1
- io_wdata  in  DATA_W  IO write data
- io_gnt  out  1  IO owns the port this cycle
- io_rvalid  out  1  IO read data valid
- io_rdata  out  DATA_W  IO read data
- mem_wEn  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_dataIn  out  DATA_W  RAM write data
- mem_access_type  out  3  RAM access type
- mem_dataOut  in  DATA_W  RAM read data, valid one cycle after address

Behaviour:
- States: ARB, IO_BURST. Reset goes to ARB.
- Reset values: all counters 0; rvalid outputs 0; burst_addr 0. Grants are forced to 0 while reset_n=0.
- Grants are combinational (Mealy) from state and requests. At most one grant is high per cycle. No grant ever goes to a requester whose req is low.
- Arbitration in ARB, evaluated in this order:
  - starve_cnt==STARVE_MAX and io_req: io_gnt=1.
  - else cpu_req: cpu_gnt=1.
  - else io_req: io_gnt=1.
- Port mux: mem_* is driven from the granted requester. With no grant, mem_wEn=0 and mem_addr, mem_dataIn and mem_access_type hold 0.
- IO access_type is fixed at 3'b010 (word).
- starve_cnt:
  - increments (saturating at STARVE_MAX) on cycles with io_req & ~io_gnt;
  - clears on io_gnt;
  - holds otherwise.
- Burst entry: io_gnt in ARB with io_burst=1.
  - That cycle is beat 0 at mem_addr=io_addr.
  - Register burst_addr=io_addr+1 and beat_cnt=BURST_LEN-1, then go to IO_BURST.
- IO_BURST:
  - cpu_gnt=0 and io_gnt=io_req.
  - mem_addr=burst_addr. The requester supplies io_we/io_wdata per beat; io_addr is ignored.
  - On each io_gnt: burst_addr+=1 (wraps mod 2^ADDR_W, 4095 to 0) and beat_cnt-=1.
  - When the beat with beat_cnt==1 is granted, return to ARB next cycle.
  - io_req low in IO_BURST aborts the burst: return to ARB next cycle with no grant that cycle.
- Read return:
  - rvalid_x registers (gnt_x & ~we_x).
  - rdata_x = mem_dataOut when rvalid_x, else 0. Latency is 1 cycle.
  - In a burst, read data returns in beat order, back-to-back.
- A write grant completes in the same cycle; no rvalid is produced.
- reset_n asserted mid-burst: immediate return to ARB, pending rvalid dropped, no further RAM write.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds three outputs, each a saturating 16-bit counter:
  - stat_cpu_grants: counts cpu_gnt cycles;
  - stat_io_grants: counts io_gnt cycles;
  - stat_conflicts: counts cycles with cpu_req & io_req both high.
  - Also adds input stat_clr, which synchronously zeroes all three counters.
  - Counters reset to 0.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state enum {ARB, IO_BURST};
  - ACCESS_WORD = 3'b010;
  - default ADDR_W/DATA_W constants.
- One natural sub-module, arb_burst_ctr: holds burst_addr and beat_cnt, with load, step, wrap and last-beat flag.

Test Plan:
- Read latency: reset, preload RAM[5]=0xDEADBEEF, cpu_req load addr 5 -> cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF next cycle.
- Conflict: cpu_req and io_req both held high every cycle, STARVE_MAX=8 -> cpu_gnt cycles 0-7, io_gnt cycle 8, starve_cnt back to 0, CPU wins cycle 9.
- Burst with wrap: io_burst read at io_addr=4090, BURST_LEN=16, cpu_req held high -> mem_addr 4090..4095, then 0..9; cpu_gnt=0 for all 16 beats, 16 io_rvalid pulses in order, CPU granted on cycle 17.
- Abort: io_req dropped after beat 3 of a burst -> ARB next cycle, cpu_req granted, no extra io_rvalid after beat 3's data.
- Reset mid-burst: reset_n low at beat 5 -> grants 0, rvalids 0, mem_wEn 0 during reset; first post-reset io_req starts a new burst at the new io_addr.
- Stats (DMEM_ARB_STATS_EN defined): 10 conflicting cycles -> stat_conflicts=10, stat_cpu_grants=9, stat_io_grants=1 (STARVE_MAX=8); stat_clr -> all three counters 0 next cycle.
